// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pong_pkg
// Purpose  : Phase encoding, serve-direction constants and score helper
//            shared by the pong match sequencer, renderer and physics.
// Revision : 1.0  initial release
// ============================================================================
package pong_pkg;

  localparam logic [2:0] PH_MENU   = 3'd0;
  localparam logic [2:0] PH_SERVE  = 3'd1;
  localparam logic [2:0] PH_PLAY   = 3'd2;
  localparam logic [2:0] PH_POINT  = 3'd3;
  localparam logic [2:0] PH_OVER   = 3'd4;
  localparam logic [2:0] PH_PAUSED = 3'd5;

  localparam logic SERVE_LEFT  = 1'b0;
  localparam logic SERVE_RIGHT = 1'b1;

  localparam int DEFAULT_WIN_SCORE = 7;

  typedef enum logic [2:0] {
    ST_MENU   = PH_MENU,
    ST_SERVE  = PH_SERVE,
    ST_PLAY   = PH_PLAY,
    ST_POINT  = PH_POINT,
    ST_OVER   = PH_OVER,
    ST_PAUSED = PH_PAUSED
  } phase_e;

  // Score increment that sticks at the 4-bit ceiling.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pong_frame_timer.sv
`default_nettype none
// ============================================================================
// Module   : pong_frame_timer
// Purpose  : Loadable frame down-counter; expire pulses on a frame tick that
//            finds the count already at zero.
// Revision : 1.0  initial release
// ============================================================================
module pong_frame_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk_0,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expire
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Load wins over a coincident tick so a fresh timed state starts full.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (frame_tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_0) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = frame_tick && (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/pong_match_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pong_match_sequencer
// Purpose  : Match flow FSM and score keeping for the pong engine; gates the
//            physics and drives renderer phase flags. Optional pause support
//            is built when PONG_PAUSE_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
module pong_match_sequencer
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = DEFAULT_WIN_SCORE,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int OVER_FRAMES  = 120,
  parameter int CNT_W        = 8
) (
  input  logic       clk_0,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start_trigger,
  input  logic [1:0] mode_choice,
  input  logic       point_p1,
  input  logic       point_p2,
  input  logic       pause_req,
  output logic [2:0] phase,
  output logic [1:0] mode_latched,
  output logic       ball_run,
  output logic       ball_respawn,
  output logic       serve_dir,
  output logic       sq_shown,
  output logic [3:0] score_p1,
  output logic [3:0] score_p2,
  output logic       game_over,
  output logic       game_startup
);

  localparam logic [3:0]       WIN_SCORE_4 = 4'(WIN_SCORE);
  localparam logic [CNT_W-1:0] SERVE_LOAD  = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LOAD  = CNT_W'(POINT_FRAMES - 1);
  localparam logic [CNT_W-1:0] OVER_LOAD   = CNT_W'(OVER_FRAMES - 1);

  phase_e     state_q, state_d;
  logic [3:0] score_p1_q, score_p1_d;
  logic [3:0] score_p2_q, score_p2_d;
  logic [1:0] mode_q, mode_d;
  logic       serve_dir_q, serve_dir_d;
  logic       armed_q, armed_d;
  logic       respawn_q, respawn_d;
  logic       ball_run_q, ball_run_d;
  logic       sq_shown_q, sq_shown_d;
  logic       game_over_q, game_over_d;
  logic       startup_q, startup_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_expire;
  logic [3:0]       new_score;

  pong_frame_timer #(
    .CNT_W (CNT_W)
  ) u_frame_timer (
    .clk_0      (clk_0),
    .rst        (rst),
    .frame_tick (frame_tick),
    .load       (tmr_load),
    .load_val   (tmr_val),
    .expire     (tmr_expire)
  );

`ifndef PONG_PAUSE_EN
  logic unused_pause;
  assign unused_pause = pause_req;
`endif

  always_comb begin
    state_d     = state_q;
    score_p1_d  = score_p1_q;
    score_p2_d  = score_p2_q;
    mode_d      = mode_q;
    serve_dir_d = serve_dir_q;
    armed_d     = armed_q;
    respawn_d   = 1'b0;
    tmr_load    = 1'b0;
    tmr_val     = '0;
    new_score   = '0;

    case (state_q)
      ST_MENU: begin
        if (start_trigger) begin
          score_p1_d  = '0;
          score_p2_d  = '0;
          mode_d      = mode_choice;
          serve_dir_d = SERVE_RIGHT;
          respawn_d   = 1'b1;
          tmr_load    = 1'b1;
          tmr_val     = SERVE_LOAD;
          state_d     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (tmr_expire) begin
          state_d = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (point_p1 || point_p2) begin
          // p1 takes precedence; the loser of the point receives the serve.
          if (point_p1) begin
            new_score   = sat_inc(score_p1_q);
            score_p1_d  = new_score;
            serve_dir_d = SERVE_LEFT;
          end else begin
            new_score   = sat_inc(score_p2_q);
            score_p2_d  = new_score;
            serve_dir_d = SERVE_RIGHT;
          end
          tmr_load = 1'b1;
          if (new_score == WIN_SCORE_4) begin
            tmr_val = OVER_LOAD;
            armed_d = 1'b0;
            state_d = ST_OVER;
          end else begin
            tmr_val = POINT_LOAD;
            state_d = ST_POINT;
          end
        end
`ifdef PONG_PAUSE_EN
        else if (pause_req) begin
          state_d = ST_PAUSED;
        end
`endif
      end
      ST_POINT: begin
        if (tmr_expire) begin
          respawn_d = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = SERVE_LOAD;
          state_d   = ST_SERVE;
        end
      end
      ST_OVER: begin
        if (tmr_expire) begin
          armed_d = 1'b1;
        end
        if (armed_q && start_trigger) begin
          state_d = ST_MENU;
        end
      end
`ifdef PONG_PAUSE_EN
      ST_PAUSED: begin
        if (pause_req) begin
          state_d = ST_PLAY;
        end
      end
`endif
      default: state_d = ST_MENU;
    endcase

    ball_run_d  = (state_d == ST_PLAY);
    sq_shown_d  = (state_d == ST_SERVE) || (state_d == ST_PLAY) ||
                  (state_d == ST_PAUSED);
    game_over_d = (state_d == ST_OVER);
    startup_d   = (state_d == ST_MENU);
  end

  always_ff @(posedge clk_0) begin
    if (rst) begin
      state_q     <= ST_MENU;
      score_p1_q  <= '0;
      score_p2_q  <= '0;
      mode_q      <= '0;
      serve_dir_q <= SERVE_RIGHT;
      armed_q     <= 1'b0;
      respawn_q   <= 1'b0;
      ball_run_q  <= 1'b0;
      sq_shown_q  <= 1'b0;
      game_over_q <= 1'b0;
      startup_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      score_p1_q  <= score_p1_d;
      score_p2_q  <= score_p2_d;
      mode_q      <= mode_d;
      serve_dir_q <= serve_dir_d;
      armed_q     <= armed_d;
      respawn_q   <= respawn_d;
      ball_run_q  <= ball_run_d;
      sq_shown_q  <= sq_shown_d;
      game_over_q <= game_over_d;
      startup_q   <= startup_d;
    end
  end

  assign phase        = state_q;
  assign mode_latched = mode_q;
  assign ball_run     = ball_run_q;
  assign ball_respawn = respawn_q;
  assign serve_dir    = serve_dir_q;
  assign sq_shown     = sq_shown_q;
  assign score_p1     = score_p1_q;
  assign score_p2     = score_p2_q;
  assign game_over    = game_over_q;
  assign game_startup = startup_q;

endmodule
`default_nettype wire
